sher_fetch_queue: RTL and testbench
===================================

Name: sher_fetch_queue

Overview:
- Instruction fetch stage directly upstream of the SHER VI instruction registers (IRO/IRT) and control FSM.
- Fetches each 32-bit instruction as two 16-bit words: low word at PC, high word at PC+2. Buffers completed pairs in a small FIFO and hands them downstream with a valid/ready handshake.
- Owns the fetch PC, advancing it by 4 per instruction. On a redirect (taken jump/branch), flushes the FIFO and restarts at the new PC.

Parameters:
- DATA_WIDTH, 16, memory word width and IRO/IRT width
- ADDR_WIDTH, 16, byte address width
- DEPTH, 2, FIFO capacity in instruction pairs (power of two, >=2)
- RESET_PC, 0, fetch PC after reset

Ports:
- CLK  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (reset=0 resets)
- mem_req  out  1  read request; held high until mem_ack
- mem_addr  out  ADDR_WIDTH  word byte-address; stable while mem_req=1
- mem_ack  in  1  read complete; mem_rdata valid this cycle
- mem_rdata  in  DATA_WIDTH  read data
- redirect  in  1  one-cycle pulse: flush and refetch from redirect_pc
- redirect_pc  in  ADDR_WIDTH  new fetch PC; bit 0 forced to 0
- inst_valid  out  1  FIFO head holds a valid pair
- inst_ready  in  1  consumer accepts head when inst_valid=1
- IRO  out  DATA_WIDTH  head low word
- IRT  out  DATA_WIDTH  head high word
- inst_pc  out  ADDR_WIDTH  head instruction address
- halted  out  1  halt instruction fetched; fetch stopped

Behaviour:
- Reset (async, reset=0):
  - pc=RESET_PC; FIFO empty (rd_ptr=wr_ptr=count=0).
  - State=FETCH_LO, mem_req=0, mem_addr=0.
  - inst_valid=0, IRO=IRT=0, inst_pc=0, halted=0.
- Reset mid-request: the request is abandoned. The memory side is reset by the same signal.
- FSM states: FETCH_LO, FETCH_HI, DRAIN, HALT.
- FETCH_LO:
  - If count<DEPTH: mem_req=1, mem_addr=pc. On mem_ack, latch the low word and go to FETCH_HI.
  - If count==DEPTH: mem_req=0 and stay.
  - Request issue is registered: mem_req rises the cycle after the space condition holds.
- FETCH_HI: mem_req=1, mem_addr=pc+2. On mem_ack:
  - push {lo, mem_rdata, pc};
  - pc<=pc+4 (mod 2^ADDR_WIDTH, wraps silently);
  - go to FETCH_LO, or to HALT if the optional feature fires.
  - The push never overflows: FETCH_LO only starts with space, and only pops occur in between.
- Single outstanding request only. mem_req never drops without mem_ack, except on reset.
- Pop: inst_valid && inst_ready advances rd_ptr. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- Minimum latency, empty FIFO with zero-wait memory (mem_ack same cycle as mem_req): inst_valid rises 3 cycles after the cycle FETCH_LO sees space (req-lo, req-hi, push visible).
- Redirect has priority over every other event in the same cycle:
  - FIFO flushed (count=0, inst_valid=0 next cycle); any simultaneous pop is ignored.
  - pc<=redirect_pc with bit0 cleared; halted cleared.
  - If no request is outstanding, or mem_ack arrives the same cycle: ack data discarded, next state FETCH_LO.
  - If a request is outstanding without ack: go to DRAIN.
- DRAIN: keep mem_req/mem_addr unchanged until mem_ack. Discard the data, then go to FETCH_LO. A second redirect during DRAIN updates pc only.
- HALT: mem_req=0. FIFO still drains to the consumer. Exit only via redirect (to FETCH_LO) or reset.
- IRO/IRT/inst_pc show FIFO head contents; they hold their last value when inst_valid=0.

Optional Feature:
- Macro: SHER_FETCH_HALT_DETECT_EN.
- Defined:
  - A pushed pair with lo==16'h8053 and hi==16'h0000 sets halted=1 (registered with the push) and moves the FSM to HALT after the push.
  - The halt pair itself is still delivered downstream.
- Undefined: no compare logic, halted tied 0, HALT state unreachable, fetch continues past 0x8053/0x0000.

Test Plan:
- Reset release, RESET_PC=0, zero-wait memory returning addr-as-data, inst_ready=1 -> pairs (0x0000,0x0002)@0, (0x0004,0x0006)@4, (0x0008,0x000A)@8 in order. First inst_valid 3 cycles after the first FETCH_LO space cycle; no gaps or duplicates.
- inst_ready=0 with DEPTH=2 -> exactly 2 pairs buffered, then mem_req=0 with pc=8. Raise inst_ready for 1 cycle -> one pop, then one new fetch at pc 8/10.
- Memory acks with 3-cycle wait; redirect to 0x0040 pulsed during a pending FETCH_HI -> mem_req held until ack, data dropped. Next request addr=0x0040, FIFO empty, no stale pair delivered.
- Redirect asserted the same cycle as mem_ack on the high word and inst_ready=1 with valid head -> no push, no pop counted, next mem_addr=redirect_pc.
- With SHER_FETCH_HALT_DETECT_EN, memory returns 0x8053/0x0000 at pc 0x000C -> pair delivered, halted=1, mem_req stays 0 for 20 cycles. Redirect to 0 -> halted=0, fetch resumes at 0. Without the macro: fetch continues at 0x0010.
- Assert reset=0 asynchronously mid-FETCH_HI -> mem_req, inst_valid and halted drop immediately (before the next edge); pc=RESET_PC after release.

Source files
------------

// File: rtl/sher_fetch_queue_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sher_fetch_queue_if : memory, redirect and instruction handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface sher_fetch_queue_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] IRO;
  logic [DATA_WIDTH-1:0] IRT;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic                  halted;

  modport master (
    output mem_req, mem_addr, inst_valid, IRO, IRT, inst_pc, halted,
    input  mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, IRO, IRT, inst_pc, halted,
    output mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface
`default_nettype wire

// File: rtl/sher_fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sher_fetch_queue : two-word instruction fetch with pair FIFO and redirect
// Optional halt detection: SHER_FETCH_HALT_DETECT_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module sher_fetch_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 2,
  parameter int RESET_PC   = 0
) (
  input  logic               CLK,
  input  logic               reset,
  sher_fetch_queue_if.master bus
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = $clog2(DEPTH + 1);
  localparam logic [C_CNT_W-1:0]    C_CNT_FULL = C_CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] C_RESET_PC = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] C_STEP     = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] C_HALF     = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] C_BIT0     = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    FETCH_LO = 2'd0,
    FETCH_HI = 2'd1,
    DRAIN    = 2'd2,
    HALT     = 2'd3
  } state_t;

  state_t                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] pc_q,       pc_d;
  logic [DATA_WIDTH-1:0] lo_q,       lo_d;
  logic                  mem_req_q,  mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [C_PTR_W-1:0]    rd_ptr_q,   rd_ptr_d;
  logic [C_PTR_W-1:0]    wr_ptr_q,   wr_ptr_d;
  logic [C_CNT_W-1:0]    count_q,    count_d;
  logic                  halted_q,   halted_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [DATA_WIDTH-1:0] iro_q,      iro_d;
  logic [DATA_WIDTH-1:0] irt_q,      irt_d;
  logic [ADDR_WIDTH-1:0] inst_pc_q,  inst_pc_d;
  logic [DATA_WIDTH-1:0] fifo_lo_q [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_lo_d [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_hi_q [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_hi_d [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_q [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_d [DEPTH];

  logic w_ack;
  logic w_pop;
  logic w_push;
  logic w_halt_hit;

  // Acks are only meaningful against our own outstanding request.
  assign w_ack = mem_req_q & bus.mem_ack;
  assign w_pop = inst_valid_q & bus.inst_ready;

`ifdef SHER_FETCH_HALT_DETECT_EN
  assign w_halt_hit = (lo_q == DATA_WIDTH'(16'h8053)) && (bus.mem_rdata == '0);
`else
  assign w_halt_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    lo_d       = lo_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    halted_d   = halted_q;
    fifo_lo_d  = fifo_lo_q;
    fifo_hi_d  = fifo_hi_q;
    fifo_pc_d  = fifo_pc_q;
    w_push     = 1'b0;

    if (bus.redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = bus.redirect_pc & ~C_BIT0;
      halted_d = 1'b0;
      // An unacked request must still complete on the bus; its data is dropped.
      if (mem_req_q && !bus.mem_ack) begin
        state_d = DRAIN;
      end else begin
        state_d   = FETCH_LO;
        mem_req_d = 1'b0;
      end
    end else begin
      case (state_q)
        FETCH_LO: begin
          if (mem_req_q) begin
            if (w_ack) begin
              lo_d       = bus.mem_rdata;
              mem_addr_d = pc_q + C_HALF;
              state_d    = FETCH_HI;
            end
          end else if (count_q != C_CNT_FULL) begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end
        end
        FETCH_HI: begin
          if (w_ack) begin
            w_push    = 1'b1;
            pc_d      = pc_q + C_STEP;
            mem_req_d = 1'b0;
            if (w_halt_hit) begin
              state_d  = HALT;
              halted_d = 1'b1;
            end else begin
              state_d = FETCH_LO;
            end
          end
        end
        DRAIN: begin
          if (w_ack) begin
            mem_req_d = 1'b0;
            state_d   = FETCH_LO;
          end
        end
        HALT: begin
          mem_req_d = 1'b0;
        end
        default: begin
          state_d   = FETCH_LO;
          mem_req_d = 1'b0;
        end
      endcase

      if (w_push) begin
        fifo_lo_d[wr_ptr_q] = lo_q;
        fifo_hi_d[wr_ptr_q] = bus.mem_rdata;
        fifo_pc_d[wr_ptr_q] = pc_q;
        wr_ptr_d            = wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (w_push && !w_pop) begin
        count_d = count_q + 1'b1;
      end else if (!w_push && w_pop) begin
        count_d = count_q - 1'b1;
      end
    end

    // Head outputs are registered from the post-update FIFO and hold when empty.
    inst_valid_d = (count_d != '0);
    iro_d        = iro_q;
    irt_d        = irt_q;
    inst_pc_d    = inst_pc_q;
    if (count_d != '0) begin
      iro_d     = fifo_lo_d[rd_ptr_d];
      irt_d     = fifo_hi_d[rd_ptr_d];
      inst_pc_d = fifo_pc_d[rd_ptr_d];
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH_LO;
      pc_q         <= C_RESET_PC;
      lo_q         <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      halted_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      iro_q        <= '0;
      irt_q        <= '0;
      inst_pc_q    <= '0;
      fifo_lo_q    <= '{default: '0};
      fifo_hi_q    <= '{default: '0};
      fifo_pc_q    <= '{default: '0};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      lo_q         <= lo_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      halted_q     <= halted_d;
      inst_valid_q <= inst_valid_d;
      iro_q        <= iro_d;
      irt_q        <= irt_d;
      inst_pc_q    <= inst_pc_d;
      fifo_lo_q    <= fifo_lo_d;
      fifo_hi_q    <= fifo_hi_d;
      fifo_pc_q    <= fifo_pc_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.IRO        = iro_q;
  assign bus.IRT        = irt_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.halted     = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_sher_fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sher_fetch_queue : directed bench with pair scoreboard for sher_fetch_queue
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sher_fetch_queue;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  int          errors    = 0;
  int          checks    = 0;
  int          delivered = 0;
  logic [15:0] last_pc   = '0;
  bit          halt_inject = 1'b0;
  int unsigned mem_wait  = 0;
  int unsigned wcnt      = 0;

  typedef struct packed {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [15:0] pc;
  } pair_t;
  pair_t sbq[$];

  sher_fetch_queue_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus();

  sher_fetch_queue #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(2), .RESET_PC(0)
  ) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory: addr-as-data, optional halt pair at 0x000C, fixed wait states.
  assign bus.mem_ack   = bus.mem_req && (wcnt >= mem_wait);
  assign bus.mem_rdata = (halt_inject && bus.mem_addr == 16'h000C) ? 16'h8053 :
                         (halt_inject && bus.mem_addr == 16'h000E) ? 16'h0000 :
                         bus.mem_addr;

  always @(posedge clk or negedge reset) begin
    if (!reset)                          wcnt <= 0;
    else if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
    else                                 wcnt <= 0;
  end

  function automatic logic [15:0] mdata(input logic [15:0] a);
    if (halt_inject && a == 16'h000C) return 16'h8053;
    if (halt_inject && a == 16'h000E) return 16'h0000;
    return a;
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pairs(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      a = start + 16'(4 * i);
      sbq.push_back({mdata(a), mdata(a + 16'd2), a});
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int unsigned wt, input bit ready, input bit inj);
    reset           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = ready;
    mem_wait        = wt;
    halt_inject     = inj;
    step(2);
    sbq.delete();
    delivered = 0;
    push_pairs(16'h0000, 16);
    reset = 1'b1;
  endtask

  // Consumer-side scoreboard; redirect cycles never count as a pop.
  always @(negedge clk) begin
    if (reset && !bus.redirect && bus.inst_valid && bus.inst_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        assert (0) else begin
          errors++;
          $error("FAIL sb_unexpected observed pc=%0h expected no pair", bus.inst_pc);
        end
      end else begin
        pair_t e;
        e = sbq.pop_front();
        chk("sb_pair", {bus.IRO, bus.IRT, bus.inst_pc}, {e.lo, e.hi, e.pc});
        delivered++;
        last_pc = bus.inst_pc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b1;

    // Reset values and minimum latency
    step(2);
    chk("rst_mem_req",    bus.mem_req,    0);
    chk("rst_mem_addr",   bus.mem_addr,   0);
    chk("rst_inst_valid", bus.inst_valid, 0);
    chk("rst_ir",         {bus.IRO, bus.IRT, bus.inst_pc}, 0);
    chk("rst_halted",     bus.halted,     0);
    push_pairs(16'h0000, 16);
    reset = 1'b1;
    step();
    chk("lat_e1_req",   {bus.mem_req, bus.mem_addr, bus.inst_valid}, {1'b1, 16'h0000, 1'b0});
    step();
    chk("lat_e2_req",   {bus.mem_req, bus.mem_addr, bus.inst_valid}, {1'b1, 16'h0002, 1'b0});
    step();
    chk("lat_e3_valid", bus.inst_valid, 1);
    chk("lat_e3_head",  {bus.IRO, bus.IRT, bus.inst_pc}, {16'h0000, 16'h0002, 16'h0000});
    for (int i = 0; i < 40 && delivered < 3; i++) step();
    chk("seq_count",   delivered, 3);
    chk("seq_last_pc", last_pc, 16'h0008);

    // Backpressure fills DEPTH pairs, one pop admits one fetch
    do_reset(0, 1'b0, 1'b0);
    step(20);
    chk("full_req",  bus.mem_req, 0);
    chk("full_head", {bus.inst_valid, bus.IRO, bus.IRT, bus.inst_pc}, {1'b1, 16'h0000, 16'h0002, 16'h0000});
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    chk("one_pop", delivered, 1);
    for (int i = 0; i < 20 && !bus.mem_req; i++) step();
    chk("refetch_addr", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0008});
    step(20);
    chk("refill_head", {bus.mem_req, bus.IRT, bus.inst_pc}, {1'b0, 16'h0006, 16'h0004});
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 40 && delivered < 3; i++) step();
    chk("refill_last_pc", last_pc, 16'h0008);

    // Redirect during pending high-word fetch with wait states
    do_reset(3, 1'b1, 1'b0);
    for (int i = 0; i < 60 && !(bus.mem_req && bus.mem_addr == 16'h0002); i++) step();
    chk("pend_hi", {bus.mem_req, bus.mem_addr, bus.mem_ack}, {1'b1, 16'h0002, 1'b0});
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0041;
    sbq.delete();
    delivered = 0;
    push_pairs(16'h0040, 16);
    step();
    bus.redirect = 1'b0;
    chk("drain_hold", {bus.mem_req, bus.mem_addr, bus.inst_valid}, {1'b1, 16'h0002, 1'b0});
    for (int i = 0; i < 20 && bus.mem_req; i++) step();
    chk("drain_done", bus.mem_req, 0);
    for (int i = 0; i < 20 && !bus.mem_req; i++) step();
    chk("redir_addr", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0040});
    for (int i = 0; i < 40 && !bus.inst_valid; i++) step();
    chk("redir_head", {bus.inst_valid, bus.IRO, bus.IRT, bus.inst_pc}, {1'b1, 16'h0040, 16'h0042, 16'h0040});

    // Redirect coincident with high-word ack and a pop
    do_reset(0, 1'b0, 1'b0);
    for (int i = 0; i < 30 && !(bus.mem_req && bus.mem_addr == 16'h0006); i++) step();
    chk("coinc_pre", {bus.mem_ack, bus.inst_valid}, 2'b11);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0100;
    bus.inst_ready  = 1'b1;
    sbq.delete();
    delivered = 0;
    push_pairs(16'h0100, 16);
    step();
    bus.redirect   = 1'b0;
    bus.inst_ready = 1'b0;
    chk("coinc_flush", {bus.inst_valid, bus.mem_req, bus.IRT, bus.inst_pc}, {1'b0, 1'b0, 16'h0002, 16'h0000});
    step();
    chk("coinc_addr", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0100});
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 40 && delivered < 1; i++) step();
    chk("coinc_first_pc", {delivered[15:0], last_pc}, {16'd1, 16'h0100});

    // Halt pair at 0x000C
    do_reset(0, 1'b1, 1'b1);
    for (int i = 0; i < 80 && delivered < 4; i++) step();
    chk("halt_pair_pc", {delivered[15:0], last_pc}, {16'd4, 16'h000C});
`ifdef SHER_FETCH_HALT_DETECT_EN
    begin
      bit req_seen;
      req_seen = 1'b0;
      chk("halt_set", bus.halted, 1);
      for (int i = 0; i < 20; i++) begin
        step();
        req_seen = req_seen | bus.mem_req;
      end
      chk("halt_no_req", {req_seen, bus.inst_valid}, 2'b00);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0000;
      sbq.delete();
      delivered = 0;
      push_pairs(16'h0000, 16);
      step();
      bus.redirect = 1'b0;
      chk("halt_clear", bus.halted, 0);
      for (int i = 0; i < 20 && !bus.mem_req; i++) step();
      chk("halt_resume", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0000});
      for (int i = 0; i < 100 && !bus.halted; i++) step();
      chk("halt_again", bus.halted, 1);
      #3 reset = 1'b0;
      #1;
      chk("halt_async_rst", bus.halted, 0);
      step();
    end
`else
    for (int i = 0; i < 40 && delivered < 5; i++) step();
    chk("nohalt_continue", {delivered[15:0], last_pc, 15'd0, bus.halted}, {16'd5, 16'h0010, 16'd0});
`endif

    // Asynchronous reset mid high-word fetch
    do_reset(3, 1'b0, 1'b0);
    for (int i = 0; i < 80 && !(bus.mem_req && bus.mem_addr == 16'h0006); i++) step();
    chk("arst_pre", {bus.mem_req, bus.mem_addr, bus.inst_valid}, {1'b1, 16'h0006, 1'b1});
    #3 reset = 1'b0;
    #1;
    chk("arst_outputs", {bus.mem_req, bus.inst_valid, bus.halted}, 3'b000);
    step();
    sbq.delete();
    reset = 1'b1;
    for (int i = 0; i < 20 && !bus.mem_req; i++) step();
    chk("arst_restart", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
